// File: rtl/cpu_reg_pkg.sv
// ---------------------------------------------------------------------------
// cpu_reg_pkg
//  Shared definitions for the general-purpose register set and the control
//  unit decoder that drives it.
//
//  Contents
//   OP_W        width of the register-op field
//   reg_op_e    op encodings: OP_LOAD / OP_INC / OP_DEC / OP_CLR
//   reg_wr_t    packed write request (enable + op) as issued by decode
//   op_is_arith helper: true for the ops that can wrap around (INC/DEC)
// ---------------------------------------------------------------------------
package cpu_reg_pkg;

    localparam int OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_LOAD = 2'b00,
        OP_INC  = 2'b01,
        OP_DEC  = 2'b10,
        OP_CLR  = 2'b11
    } reg_op_e;

    // Write request as the control unit presents it to the register set.
    typedef struct packed {
        logic    en;
        reg_op_e op;
    } reg_wr_t;

    // INC and DEC are the only ops whose result can wrap modulo 2**width.
    function automatic logic op_is_arith(input reg_op_e op);
        return (op == OP_INC) || (op == OP_DEC);
    endfunction

endpackage : cpu_reg_pkg

// File: rtl/reg_next_val.sv
// ---------------------------------------------------------------------------
// reg_next_val
//  Purely combinational next-value generator for one register write port.
//  Given the current register contents, the op and the load data, produces
//  the value the register takes at the next edge and whether that update
//  wraps around (INC of all-ones, DEC of zero).
//
//  Parameters
//   word_size  register width in bits (>=2)
//
//  Ports
//   op       in   reg_op_e    operation to apply
//   cur      in   word_size   current register contents
//   d_in     in   word_size   load data (used only by OP_LOAD)
//   next_val out  word_size   resulting register value
//   wrapped  out  1           update crosses the modulo boundary
// ---------------------------------------------------------------------------
module reg_next_val
    import cpu_reg_pkg::*;
#(
    parameter int word_size = 8
) (
    input  reg_op_e              op,
    input  logic [word_size-1:0] cur,
    input  logic [word_size-1:0] d_in,
    output logic [word_size-1:0] next_val,
    output logic                 wrapped
);

    localparam logic [word_size-1:0] ONE = {{(word_size-1){1'b0}}, 1'b1};

    logic at_max;
    logic at_zero;

    assign at_max  = &cur;
    assign at_zero = ~|cur;

    always_comb begin
        next_val = cur;
        wrapped  = 1'b0;
        case (op)
            OP_LOAD: next_val = d_in;
            OP_INC: begin
                next_val = cur + ONE;
                wrapped  = at_max;
            end
            OP_DEC: begin
                next_val = cur - ONE;
                wrapped  = at_zero;
            end
            OP_CLR:  next_val = '0;
            default: next_val = cur;
        endcase
        // Belt-and-braces: only arithmetic ops are ever allowed to flag a wrap.
        if (!op_is_arith(op)) begin
            wrapped = 1'b0;
        end
    end

endmodule : reg_next_val

// File: rtl/register_bank.sv
// ---------------------------------------------------------------------------
// register_bank
//  General-purpose register set: NUM_REGS words of word_size bits with one
//  write/modify port (LOAD/INC/DEC/CLR in place) and two independent
//  combinational read ports. Each register carries a valid bit that is set
//  by any write since reset; a registered one-cycle wrap pulse reports that
//  the previous op overflowed or underflowed.
//
//  Parameters
//   word_size  8  register width in bits (>=2)
//   NUM_REGS   4  register count, power of two, >=2
//
//  Ports
//   clk        in   1          rising-edge clock
//   rst        in   1          synchronous reset, active low
//   load       in   1          modify enable; 0 = all registers hold
//   op         in   2          00 LOAD, 01 INC, 10 DEC, 11 CLR
//   wr_addr    in   ADDR_W     target register of op
//   d_in       in   word_size  LOAD data
//   rd_addr_a  in   ADDR_W     read port A address
//   rd_addr_b  in   ADDR_W     read port B address
//   d_out_a    out  word_size  reg[rd_addr_a]
//   d_out_b    out  word_size  reg[rd_addr_b]
//   valid_a    out  1          reg[rd_addr_a] written since reset
//   valid_b    out  1          reg[rd_addr_b] written since reset
//   wrap       out  1          last op wrapped (one-cycle pulse)
//
//  Build option
//   REG_BYPASS_EN  when defined, a read port addressing the register being
//                  written shows the next value in the same cycle (and
//                  valid=1); suppressed while rst is asserted. When not
//                  defined, read ports always show the stored value.
// ---------------------------------------------------------------------------
module register_bank
    import cpu_reg_pkg::*;
#(
    parameter int word_size = 8,
    parameter int NUM_REGS  = 4,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [OP_W-1:0]      op,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [word_size-1:0] d_in,
    input  logic [ADDR_W-1:0]    rd_addr_a,
    input  logic [ADDR_W-1:0]    rd_addr_b,
    output logic [word_size-1:0] d_out_a,
    output logic [word_size-1:0] d_out_b,
    output logic                 valid_a,
    output logic                 valid_b,
    output logic                 wrap
);

    // Storage. The array is reset as a whole, so it maps to flops rather
    // than block RAM; reads must also be zero-latency.
    logic [word_size-1:0] regs_reg [NUM_REGS];
    logic [NUM_REGS-1:0]  valid_reg;
    logic                 wrap_reg;

    reg_wr_t              wr_req;
    logic [word_size-1:0] cur_val;
    logic [word_size-1:0] wr_next;
    logic                 wr_wrapped;
    logic [NUM_REGS-1:0]  wr_sel;

    assign wr_req.en = load;
    assign wr_req.op = reg_op_e'(op);

    // Only the addressed register feeds the next-value logic; one instance
    // serves both the write path and the bypass path.
    assign cur_val = regs_reg[wr_addr];

    reg_next_val #(
        .word_size (word_size)
    ) u_next (
        .op       (wr_req.op),
        .cur      (cur_val),
        .d_in     (d_in),
        .next_val (wr_next),
        .wrapped  (wr_wrapped)
    );

    // One-hot write select per register.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_wr_sel
            localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);
            assign wr_sel[gi] = wr_req.en && (wr_addr == IDX);
        end
    endgenerate

    // Register file and valid bits. Reset takes priority over any pending
    // op on the same edge, so a write coincident with reset is discarded.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_reg[i] <= '0;
            end
            valid_reg <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_sel[i]) begin
                    regs_reg[i]  <= wr_next;
                    valid_reg[i] <= 1'b1;
                end
            end
        end
    end

    // Wrap pulse: high for exactly the cycle after a wrapping INC/DEC.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wrap_reg <= 1'b0;
        end else begin
            wrap_reg <= wr_req.en && wr_wrapped;
        end
    end

    assign wrap = wrap_reg;

    // Read ports.
`ifdef REG_BYPASS_EN
    logic bypass_a;
    logic bypass_b;

    // Forward the in-flight result only when the write will actually land.
    assign bypass_a = rst && wr_req.en && (rd_addr_a == wr_addr);
    assign bypass_b = rst && wr_req.en && (rd_addr_b == wr_addr);

    always_comb begin
        d_out_a = regs_reg[rd_addr_a];
        valid_a = valid_reg[rd_addr_a];
        d_out_b = regs_reg[rd_addr_b];
        valid_b = valid_reg[rd_addr_b];
        if (bypass_a) begin
            d_out_a = wr_next;
            valid_a = 1'b1;
        end
        if (bypass_b) begin
            d_out_b = wr_next;
            valid_b = 1'b1;
        end
    end
`else
    always_comb begin
        d_out_a = regs_reg[rd_addr_a];
        valid_a = valid_reg[rd_addr_a];
        d_out_b = regs_reg[rd_addr_b];
        valid_b = valid_reg[rd_addr_b];
    end
`endif

endmodule : register_bank

// File: tb/tb_register_bank.sv
// ---------------------------------------------------------------------------
// tb_register_bank
//  Directed, table-driven bench for register_bank (word_size=8, NUM_REGS=4)
//  with hand-written sequences for same-cycle read/write and reset corners.
// ---------------------------------------------------------------------------
module tb_register_bank;

    localparam logic [1:0] LD  = 2'b00;
    localparam logic [1:0] INC = 2'b01;
    localparam logic [1:0] DEC = 2'b10;
    localparam logic [1:0] CLR = 2'b11;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [1:0] op;
    logic [1:0] wr_addr;
    logic [7:0] d_in;
    logic [1:0] rd_addr_a;
    logic [1:0] rd_addr_b;
    logic [7:0] d_out_a;
    logic [7:0] d_out_b;
    logic       valid_a;
    logic       valid_b;
    logic       wrap;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    register_bank #(
        .word_size (8),
        .NUM_REGS  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .op        (op),
        .wr_addr   (wr_addr),
        .d_in      (d_in),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .d_out_a   (d_out_a),
        .d_out_b   (d_out_b),
        .valid_a   (valid_a),
        .valid_b   (valid_b),
        .wrap      (wrap)
    );

    typedef struct {
        logic       rst;
        logic       load;
        logic [1:0] op;
        logic [1:0] wa;
        logic [7:0] din;
        logic [1:0] ra;
        logic [1:0] rb;
        logic [7:0] ea;
        logic [7:0] eb;
        logic       eva;
        logic       evb;
        logic       ew;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic r, input logic l, input logic [1:0] o,
                           input logic [1:0] wa, input logic [7:0] din,
                           input logic [1:0] ra, input logic [1:0] rb,
                           input logic [7:0] ea, input logic [7:0] eb,
                           input logic eva, input logic evb, input logic ew);
        vec_t v;
        v.rst = r; v.load = l; v.op = o; v.wa = wa; v.din = din;
        v.ra = ra; v.rb = rb; v.ea = ea; v.eb = eb;
        v.eva = eva; v.evb = evb; v.ew = ew;
        vecs.push_back(v);
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    initial begin
        // -------- vector table (state after the edge, read with load=0) --------
        //       rst load op   wa  din    ra rb  ea     eb     va vb wrap
        // reset
        add_vec(0, 0, LD,  0, 8'h00, 0, 1, 8'h00, 8'h00, 0, 0, 0);
        add_vec(0, 0, LD,  0, 8'h00, 2, 3, 8'h00, 8'h00, 0, 0, 0);
        // loads and validity
        add_vec(1, 1, LD,  1, 8'hA5, 1, 0, 8'hA5, 8'h00, 1, 0, 0);
        add_vec(1, 1, LD,  2, 8'h3C, 1, 2, 8'hA5, 8'h3C, 1, 1, 0);
        add_vec(1, 0, LD,  0, 8'h00, 0, 3, 8'h00, 8'h00, 0, 0, 0);
        // wrap around
        add_vec(1, 1, LD,  3, 8'hFF, 3, 0, 8'hFF, 8'h00, 1, 0, 0);
        add_vec(1, 1, INC, 3, 8'h00, 3, 1, 8'h00, 8'hA5, 1, 1, 1);
        add_vec(1, 1, DEC, 3, 8'h00, 3, 1, 8'hFF, 8'hA5, 1, 1, 1);
        add_vec(1, 0, LD,  3, 8'h00, 3, 1, 8'hFF, 8'hA5, 1, 1, 0);
        add_vec(1, 1, LD,  3, 8'h10, 3, 1, 8'h10, 8'hA5, 1, 1, 0);
        add_vec(1, 1, INC, 3, 8'h00, 3, 1, 8'h11, 8'hA5, 1, 1, 0);
        add_vec(1, 1, DEC, 3, 8'h00, 3, 1, 8'h10, 8'hA5, 1, 1, 0);
        // load=0 holds regardless of op
        add_vec(1, 0, CLR, 1, 8'h00, 1, 2, 8'hA5, 8'h3C, 1, 1, 0);
        add_vec(1, 0, CLR, 1, 8'h00, 1, 2, 8'hA5, 8'h3C, 1, 1, 0);
        add_vec(1, 0, CLR, 1, 8'h00, 1, 2, 8'hA5, 8'h3C, 1, 1, 0);
        add_vec(1, 1, CLR, 1, 8'hFF, 1, 2, 8'h00, 8'h3C, 1, 1, 0);
        // back-to-back INC chain
        add_vec(1, 1, LD,  0, 8'hFE, 0, 1, 8'hFE, 8'h00, 1, 1, 0);
        add_vec(1, 1, INC, 0, 8'h00, 0, 1, 8'hFF, 8'h00, 1, 1, 0);
        add_vec(1, 1, INC, 0, 8'h00, 0, 1, 8'h00, 8'h00, 1, 1, 1);
        // reset coincident with load discards the op
        add_vec(0, 1, LD,  0, 8'h77, 0, 2, 8'h00, 8'h00, 0, 0, 0);
        add_vec(1, 1, LD,  0, 8'h77, 0, 2, 8'h77, 8'h00, 1, 0, 0);
        // DEC of fresh zero, CLR on unwritten reg, INC ignores d_in
        add_vec(1, 1, DEC, 2, 8'h00, 2, 0, 8'hFF, 8'h77, 1, 1, 1);
        add_vec(1, 1, CLR, 3, 8'h5A, 3, 2, 8'h00, 8'hFF, 1, 1, 0);
        add_vec(1, 1, INC, 1, 8'h33, 1, 3, 8'h01, 8'h00, 1, 1, 0);

        rst = 1'b0; load = 1'b0; op = LD; wr_addr = '0; d_in = '0;
        rd_addr_a = '0; rd_addr_b = '0;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; load = vecs[i].load; op = vecs[i].op;
            wr_addr = vecs[i].wa; d_in = vecs[i].din;
            rd_addr_a = vecs[i].ra; rd_addr_b = vecs[i].rb;
            @(posedge clk);
            #1;
            load = 1'b0;
            #1;
            $display("vec %0d: rst=%b load=%b op=%0d wa=%0d din=%h | a=%h b=%h va=%b vb=%b wrap=%b",
                     i, vecs[i].rst, vecs[i].load, vecs[i].op, vecs[i].wa, vecs[i].din,
                     d_out_a, d_out_b, valid_a, valid_b, wrap);
            check8($sformatf("vec%0d d_out_a", i), d_out_a, vecs[i].ea);
            check8($sformatf("vec%0d d_out_b", i), d_out_b, vecs[i].eb);
            check1($sformatf("vec%0d valid_a", i), valid_a, vecs[i].eva);
            check1($sformatf("vec%0d valid_b", i), valid_b, vecs[i].evb);
            check1($sformatf("vec%0d wrap", i), wrap, vecs[i].ew);
        end
        // State now: r0=77, r1=01, r2=FF, r3=00, all valid.

        // -------- same-cycle write/read of r2 with LOAD 55 --------
        @(negedge clk);
        rst = 1'b1; load = 1'b1; op = LD; wr_addr = 2'd2; d_in = 8'h55;
        rd_addr_a = 2'd2; rd_addr_b = 2'd1;
        #1;
`ifdef REG_BYPASS_EN
        check8("same-cycle load d_out_a", d_out_a, 8'h55);
`else
        check8("same-cycle load d_out_a", d_out_a, 8'hFF);
`endif
        check1("same-cycle load valid_a", valid_a, 1'b1);
        check8("same-cycle load d_out_b", d_out_b, 8'h01);
        @(posedge clk);
        #1;
        load = 1'b0;
        #1;
        $display("seq load-bypass: a=%h b=%h va=%b wrap=%b", d_out_a, d_out_b, valid_a, wrap);
        check8("after load d_out_a", d_out_a, 8'h55);

        // -------- same-cycle INC of r1 seen on both ports --------
        @(negedge clk);
        load = 1'b1; op = INC; wr_addr = 2'd1; d_in = 8'h00;
        rd_addr_a = 2'd1; rd_addr_b = 2'd1;
        #1;
`ifdef REG_BYPASS_EN
        check8("same-cycle inc d_out_a", d_out_a, 8'h02);
        check8("same-cycle inc d_out_b", d_out_b, 8'h02);
`else
        check8("same-cycle inc d_out_a", d_out_a, 8'h01);
        check8("same-cycle inc d_out_b", d_out_b, 8'h01);
`endif
        @(posedge clk);
        #1;
        load = 1'b0;
        #1;
        $display("seq inc-bypass: a=%h b=%h wrap=%b", d_out_a, d_out_b, wrap);
        check8("after inc d_out_b", d_out_b, 8'h02);

        // -------- reset with pending load: reads show stored value --------
        @(negedge clk);
        rst = 1'b0; load = 1'b1; op = LD; wr_addr = 2'd2; d_in = 8'h99;
        rd_addr_a = 2'd2; rd_addr_b = 2'd0;
        #1;
        check8("reset-pending d_out_a", d_out_a, 8'h55);
        check1("reset-pending valid_a", valid_a, 1'b1);
        @(posedge clk);
        #1;
        load = 1'b0;
        #1;
        $display("seq reset-pending: a=%h b=%h va=%b vb=%b wrap=%b",
                 d_out_a, d_out_b, valid_a, valid_b, wrap);
        check8("post-reset d_out_a", d_out_a, 8'h00);
        check1("post-reset valid_a", valid_a, 1'b0);
        check8("post-reset d_out_b", d_out_b, 8'h00);
        check1("post-reset valid_b", valid_b, 1'b0);
        check1("post-reset wrap", wrap, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_register_bank
